// File: rtl/led7219_pkg.sv
// Shared definitions for the MAX7219 serial-link receiver.
//   - Register address constants as seen in the frame address nibble.
//   - FRAME_BITS: width of one device frame on the wire.
//   - state_t: receiver FSM states.
//   - frame_t: field view of one 16-bit frame.
package led7219_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [3:0] REG_NOOP      = 4'h0;
   localparam logic [3:0] REG_DIGIT0    = 4'h1;
   localparam logic [3:0] REG_DIGIT7    = 4'h8;
   localparam logic [3:0] REG_DECODE    = 4'h9;
   localparam logic [3:0] REG_INTENSITY = 4'hA;
   localparam logic [3:0] REG_SCANLIM   = 4'hB;
   localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
   localparam logic [3:0] REG_TEST      = 4'hF;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_LATCH     = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] dc;     // don't-care nibble
      logic [3:0] addr;
      logic [7:0] value;
   } frame_t;

endpackage

// File: rtl/led7219_rx_sync_edge.sv
// sync_edge: STAGES-deep synchronizer for one asynchronous pin, followed by
// one edge-detect flop.
//   clk, rst : system clock, synchronous active-high reset
//   pin      : asynchronous input
//   lvl      : synchronized level (aligned with rise/fall)
//   rise     : 1-cycle pulse on a 0->1 transition of the synchronized level
//   fall     : 1-cycle pulse on a 1->0 transition of the synchronized level
// All outputs are registered, so lvl/rise/fall change on the same edge.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         lvl    <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         lvl    <= sync_q[STAGES-1];
         rise   <= sync_q[STAGES-1] & ~lvl;
         fall   <= ~sync_q[STAGES-1] & lvl;
      end
   end

endmodule

// File: rtl/led7219_rx.sv
// led7219_rx: receive-side decoder for the MAX7219 DIN/LOAD/CLK link.
// Collects one LOAD window of NDEV cascaded 16-bit frames and, if exactly
// 16*NDEV bits arrived, applies every device's frame in one cycle.
//   clk, rst      : system clock, synchronous active-high reset
//   din, cs, sclk : asynchronous link pins (cs active-low window)
//   data          : image, device k row r at data[k*64+(r-1)*8 +: 8]
//   intensity     : reg 0xA nibble per device
//   shutdown_n    : reg 0xC bit0 per device
//   display_test  : reg 0xF bit0 per device
//   update        : 1-cycle pulse, window applied
//   frame_err     : 1-cycle pulse, window discarded (bad bit count)
module led7219_rx
   import led7219_pkg::*;
#(
   parameter int NDEV        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din,
   input  logic                 cs,
   input  logic                 sclk,
   output logic [NDEV*64-1:0]   data,
   output logic [NDEV*4-1:0]    intensity,
   output logic [NDEV-1:0]      shutdown_n,
   output logic [NDEV-1:0]      display_test,
   output logic                 update,
   output logic                 frame_err
);

   localparam int SR_W  = FRAME_BITS * NDEV;
   localparam int CNT_W = $clog2(SR_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_W + 1);

   logic din_lvl, din_rise, din_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
      .clk(clk), .rst(rst), .pin(din),  .lvl(din_lvl),  .rise(din_rise),  .fall(din_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .pin(cs),   .lvl(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));
   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .pin(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

   // Window start is taken from the cs level rather than the fall pulse, so a
   // fall that arrived during LATCH is still honoured if cs stays low.
   logic unused_edges;
   assign unused_edges = ^{din_rise, din_fall, cs_fall, sclk_lvl, sclk_fall};

   state_t                     state;
   logic [SR_W-1:0]            sr;
   logic [CNT_W-1:0]           cnt;
   logic [NDEV-1:0][7:0][7:0]  img_q, img_nxt;
   logic [NDEV-1:0][3:0]       int_q, int_nxt;
   logic [NDEV-1:0]            shd_q, shd_nxt;
   logic [NDEV-1:0]            tst_q, tst_nxt;

   assign data         = img_q;
   assign intensity    = int_q;
   assign shutdown_n   = shd_q;
   assign display_test = tst_q;

   // Per-device decode of the shift register; only committed in LATCH.
   frame_t     fr;
   logic [2:0] row;
   logic       unused_dc;

   always_comb begin
      img_nxt   = img_q;
      int_nxt   = int_q;
      shd_nxt   = shd_q;
      tst_nxt   = tst_q;
      fr        = '0;
      row       = '0;
      unused_dc = 1'b0;
      for (int k = 0; k < NDEV; k++) begin
         fr        = frame_t'(sr[k*FRAME_BITS +: FRAME_BITS]);
         unused_dc = unused_dc ^ (^fr.dc);
         // addr 1..8 -> row 0..7; addr 8 wraps 3'b000-1 to 3'b111
         row = fr.addr[2:0] - 3'd1;
         if (fr.addr >= REG_DIGIT0 && fr.addr <= REG_DIGIT7) begin
            img_nxt[k][row] = fr.value;
         end else begin
            case (fr.addr)
               REG_INTENSITY: int_nxt[k] = fr.value[3:0];
               REG_SHUTDOWN:  shd_nxt[k] = fr.value[0];
               REG_TEST:      tst_nxt[k] = fr.value[0];
               REG_NOOP, REG_DECODE, REG_SCANLIM: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_WAIT_IDLE;
         sr        <= '0;
         cnt       <= '0;
         img_q     <= '0;
         int_q     <= '0;
         shd_q     <= '0;
         tst_q     <= '0;
         update    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         update    <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            // Refuse to start until the line has been seen idle, so a window
            // already in progress at reset release is never decoded.
            ST_WAIT_IDLE: if (cs_lvl) state <= ST_IDLE;
            ST_IDLE: begin
               if (!cs_lvl) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               // cs rise wins over a coincident sclk rise
               if (cs_rise) begin
                  state <= ST_LATCH;
               end else if (sclk_rise) begin
                  sr <= {sr[SR_W-2:0], din_lvl};
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end
            end
            ST_LATCH: begin
               state <= ST_IDLE;
               if (cnt == CNT_FULL) begin
                  img_q  <= img_nxt;
                  int_q  <= int_nxt;
                  shd_q  <= shd_nxt;
                  tst_q  <= tst_nxt;
                  update <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: state <= ST_WAIT_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led7219_rx.sv
// Self-checking bench for led7219_rx: random and directed LOAD windows are
// driven on the pins; a register-level model predicts the image, registers
// and the update/frame_err pulse cycle, and is compared every cycle.
module tb_led7219_rx;

   localparam int NDEV = 4;
   localparam int S    = 2;
   localparam int W    = 16 * NDEV;
   localparam int P    = 2;   // sclk high/low phase in clk cycles (4-clk period)

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic din = 1'b0;
   logic cs  = 1'b1;
   logic sclk = 1'b0;
   logic [NDEV*64-1:0] data;
   logic [NDEV*4-1:0]  intensity;
   logic [NDEV-1:0]    shutdown_n;
   logic [NDEV-1:0]    display_test;
   logic               update;
   logic               frame_err;

   always #5 clk = ~clk;

   led7219_rx #(.NDEV(NDEV), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .din(din), .cs(cs), .sclk(sclk),
      .data(data), .intensity(intensity), .shutdown_n(shutdown_n),
      .display_test(display_test), .update(update), .frame_err(frame_err));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tot = 0;
   int n_bad = 0;

   // model state (owned by the compare process) and pending window result
   logic [NDEV*64-1:0] m_data, p_data;
   logic [NDEV*4-1:0]  m_int,  p_int;
   logic [NDEV-1:0]    m_shd,  p_shd;
   logic [NDEV-1:0]    m_tst,  p_tst;
   int  due_cyc = -1;
   bit  due_err = 1'b0;
   int  n_upd = 0;
   int  n_err = 0;
   int  last_upd_cyc = -1;
   int  rise_cyc = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      bit eu, ee;
      if (rst) begin
         m_data = '0; m_int = '0; m_shd = '0; m_tst = '0;
      end else begin
         eu = (cyc == due_cyc) && !due_err;
         ee = (cyc == due_cyc) && due_err;
         if (eu) begin
            m_data = p_data; m_int = p_int; m_shd = p_shd; m_tst = p_tst;
         end
         if (update) begin
            n_upd++;
            last_upd_cyc = cyc;
         end
         if (frame_err) n_err++;
         chk("update", update, eu);
         chk("frame_err", frame_err, ee);
         chk("data", data, m_data);
         chk("intensity", intensity, m_int);
         chk("shutdown_n", shutdown_n, m_shd);
         chk("display_test", display_test, m_tst);
      end
   end

   // Apply one complete window: device k frame is w[16k +: 16].
   task automatic model_window(input logic [W-1:0] w);
      int addr;
      logic [7:0] val;
      p_data = m_data; p_int = m_int; p_shd = m_shd; p_tst = m_tst;
      for (int k = 0; k < NDEV; k++) begin
         addr = int'(w[16*k+8 +: 4]);
         val  = w[16*k +: 8];
         if (addr >= 1 && addr <= 8) p_data[k*64 + (addr-1)*8 +: 8] = val;
         else if (addr == 10) p_int[k*4 +: 4] = val[3:0];
         else if (addr == 12) p_shd[k] = val[0];
         else if (addr == 15) p_tst[k] = val[0];
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_out(input logic b);
      din  = b;
      sclk = 1'b0;
      tick(P);
      sclk = 1'b1;
      tick(P);
   endtask

   // send s[hi] down to s[lo], MSB first
   task automatic send_bits(input logic [127:0] s, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) bit_out(s[i]);
   endtask

   task automatic window(input logic [127:0] s, input int nbits);
      cs = 1'b0;
      tick(P);
      send_bits(s, nbits - 1, 0);
      sclk = 1'b0;
      tick(P);
      if (nbits == W) model_window(s[W-1:0]);
      due_err  = (nbits != W);
      cs       = 1'b1;
      rise_cyc = cyc;
      due_cyc  = cyc + S + 3;
      tick(S + 6);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int u0, e0, nb;
      logic [127:0] s;

      // 1: reset, idle lines
      tick(4);
      rst = 1'b0;
      tick(20);
      chk("t1_data", data, 0);
      chk("t1_intensity", intensity, 0);
      chk("t1_shutdown_n", shutdown_n, 0);
      chk("t1_display_test", display_test, 0);
      chk("t1_no_pulses", n_upd + n_err, 0);

      // 2: directed window
      s = '0;
      s[W-1:0] = {16'h0C01, 16'h0A07, 16'h083C, 16'h01A5};
      window(s, W);
      chk("t2_dev0_row1", data[7:0], 8'hA5);
      chk("t2_dev1_row8", data[127:120], 8'h3C);
      chk("t2_dev2_int", intensity[11:8], 4'h7);
      chk("t2_shutdown_n", shutdown_n, 4'b1000);
      chk("t2_update_count", n_upd, 1);
      chk("t2_update_latency", last_upd_cyc - rise_cyc, S + 3);

      // 3: short and long windows
      u0 = n_upd; e0 = n_err;
      s = {$urandom, $urandom, $urandom, $urandom};
      window(s, W - 1);
      s = {$urandom, $urandom, $urandom, $urandom};
      window(s, W + 1);
      chk("t3_err_count", n_err - e0, 2);
      chk("t3_no_update", n_upd - u0, 0);
      chk("t3_dev0_row1_kept", data[7:0], 8'hA5);

      // 4: reset in the middle of a window
      u0 = n_upd; e0 = n_err;
      s = {$urandom, $urandom, $urandom, $urandom};
      cs = 1'b0;
      tick(P);
      send_bits(s, W - 1, W - 20);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      send_bits(s, W - 21, 0);
      sclk = 1'b0;
      tick(P);
      cs = 1'b1;
      tick(S + 6);
      chk("t4_silent_drop", (n_upd - u0) + (n_err - e0), 0);
      chk("t4_cleared", data, 0);
      s = '0;
      s[W-1:0] = {16'h0F01, 16'h0C01, 16'h0A0B, 16'h0822};
      window(s, W);
      chk("t4_next_applies", n_upd - u0, 1);
      chk("t4_dev0_row8", data[63:56], 8'h22);
      chk("t4_dev3_test", display_test, 4'b1000);

      // 5: only ignored addresses
      u0 = n_upd;
      s = '0;
      for (int k = 0; k < NDEV; k++) begin
         case ($urandom_range(0, 2))
            0: s[16*k+8 +: 4] = 4'h0;
            1: s[16*k+8 +: 4] = 4'h9;
            default: s[16*k+8 +: 4] = 4'hB;
         endcase
         s[16*k +: 8] = 8'($urandom);
      end
      window(s, W);
      chk("t5_update_count", n_upd - u0, 1);
      chk("t5_dev0_row8_kept", data[63:56], 8'h22);

      // 6: random windows
      u0 = n_upd; e0 = n_err;
      for (int i = 0; i < 200; i++) begin
         s  = {$urandom, $urandom, $urandom, $urandom};
         nb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(W - 4, W + 4)) : W;
         window(s, nb);
      end
      chk("t6_pulses", (n_upd - u0) + (n_err - e0), 200);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
